cas_loader: RTL and testbench

Parses a TRS-80 SYSTEM-format cassette image (.CAS) streamed from the HPS download channel and writes its data blocks directly into the HT1080Z main RAM. It sits upstream of the ht1080z core: it consumes the core's download strobes (index ≠ 0) and drives a byte-wide RAM write port. It reports the program entry address, which lets the machine jump to the loaded program without a tape-speed CLOAD.

---
 rtl/cas_pkg.sv | 34 +++
 rtl/cas_cksum.sv | 37 +++
 rtl/cas_loader.sv | 217 +++++++++++++++++++++
 tb/tb_cas_loader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_pkg.sv
// Shared types and constants for the SYSTEM-format cassette loader.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cas_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEADER,
    ST_MARKER,
    ST_NAME,
    ST_BTYPE,
    ST_LEN,
    ST_ADRL,
    ST_ADRH,
    ST_DATA,
    ST_CKS,
    ST_ENTL,
    ST_ENTH,
    ST_DONE,
    ST_ERROR
  } cas_state_t;

  localparam logic [7:0] CAS_SYNC     = 8'hA5;
  localparam logic [7:0] CAS_SYS      = 8'h55;
  localparam logic [7:0] CAS_DATA     = 8'h3C;
  localparam logic [7:0] CAS_END      = 8'h78;
  localparam int         CAS_NAME_LEN = 6;

  // A parse is in progress in every state except the three resting states.
  function automatic logic cas_is_busy(input cas_state_t s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_ERROR);
  endfunction

endpackage

// File: rtl/cas_cksum.sv
// Per-block 8-bit running checksum: cleared, accumulated, compared to a byte.
// Latency: sum registered one cycle after add; match is combinational on the held sum.
// Backpressure: none; caller strobes clr/add at most once per accepted byte.
module cas_cksum (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] add_dat,
  input  logic [7:0] cmp_dat,
  output logic       match
);

  logic [7:0] sum_q, sum_d;

  // Next sum: clear at block start, modulo-256 add otherwise.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = 8'h00;
    end else if (add) begin
      sum_d = sum_q + add_dat;
    end
  end

  // Sum register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match = (sum_q == cmp_dat);

endmodule

// File: rtl/cas_loader.sv
// Parses a streamed .CAS SYSTEM image and writes its data blocks into main RAM.
// Latency: state and RAM write registered 1 cycle after the carrying dn_wr strobe.
// Backpressure: none; relies on dn_wr strobes being >=2 cycles apart. Macro CAS_CHECKSUM_EN.
module cas_loader
  import cas_pkg::*;
#(
  parameter logic [7:0]  CAS_IDX  = 8'd1,
  parameter logic [15:0] RAM_BASE = 16'h4000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_go,
  input  logic        dn_wr,
  input  logic [7:0]  dn_data,
  input  logic [7:0]  dn_idx,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] entry_addr,
  output logic        rom_hit
);

  cas_state_t  state_q, state_d;
  logic        go_prev_q, go_prev_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  entry_lo_q, entry_lo_d;
  logic [15:0] entry_addr_q, entry_addr_d;
  logic        rom_hit_q, rom_hit_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;

  logic start;
  logic byte_vld;
  logic ck_match;

  assign start    = dn_go && (dn_idx == CAS_IDX) && !go_prev_q;
  assign byte_vld = dn_wr && (dn_idx == CAS_IDX);
  assign go_prev_d = dn_go;

`ifdef CAS_CHECKSUM_EN
  logic ck_clr;
  logic ck_add;

  // Restart the sum at each block's length byte; seed with both address bytes.
  assign ck_clr = !start && byte_vld && (state_q == ST_LEN);
  assign ck_add = !start && byte_vld &&
                  (state_q == ST_ADRL || state_q == ST_ADRH || state_q == ST_DATA);

  cas_cksum u_cksum (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (ck_clr),
    .add     (ck_add),
    .add_dat (dn_data),
    .cmp_dat (dn_data),
    .match   (ck_match)
  );
`else
  // Checksum byte is consumed and discarded.
  assign ck_match = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // dn_go keeps being sampled through reset so a download already in flight
  // when reset drops is not mistaken for a fresh start.
  always_ff @(posedge clk_sys) begin
    go_prev_q <= go_prev_d;
  end

  // Datapath and write-port registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q        <= '0;
      addr_q       <= '0;
      entry_lo_q   <= '0;
      entry_addr_q <= '0;
      rom_hit_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      entry_lo_q   <= entry_lo_d;
      entry_addr_q <= entry_addr_d;
      rom_hit_q    <= rom_hit_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Next state and datapath: start wins, then the byte, then truncation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    entry_lo_d   = entry_lo_q;
    entry_addr_d = entry_addr_q;
    rom_hit_d    = rom_hit_q;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;

    if (start) begin
      state_d      = ST_LEADER;
      entry_addr_d = '0;
      rom_hit_d    = 1'b0;
    end else begin
      if (byte_vld) begin
        case (state_q)
          ST_LEADER: begin
            if (dn_data == CAS_SYNC) begin
              state_d = ST_MARKER;
            end else if (dn_data != 8'h00) begin
              state_d = ST_ERROR;
            end
          end
          ST_MARKER: begin
            if (dn_data == CAS_SYS) begin
              state_d = ST_NAME;
              cnt_d   = 9'(CAS_NAME_LEN);
            end else begin
              state_d = ST_ERROR;
            end
          end
          ST_NAME: begin
            cnt_d = cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              state_d = ST_BTYPE;
            end
          end
          ST_BTYPE: begin
            if (dn_data == CAS_DATA) begin
              state_d = ST_LEN;
            end else if (dn_data == CAS_END) begin
              state_d = ST_ENTL;
            end else begin
              state_d = ST_ERROR;
            end
          end
          ST_LEN: begin
            // A zero length byte encodes a full 256-byte block.
            cnt_d   = (dn_data == 8'h00) ? 9'd256 : {1'b0, dn_data};
            state_d = ST_ADRL;
          end
          ST_ADRL: begin
            addr_d[7:0] = dn_data;
            state_d     = ST_ADRH;
          end
          ST_ADRH: begin
            addr_d[15:8] = dn_data;
            state_d      = ST_DATA;
          end
          ST_DATA: begin
            if (addr_q >= RAM_BASE) begin
              mem_wr_d   = 1'b1;
              mem_addr_d = addr_q;
              mem_data_d = dn_data;
            end else begin
              rom_hit_d = 1'b1;
            end
            addr_d = addr_q + 16'd1;
            cnt_d  = cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              state_d = ST_CKS;
            end
          end
          ST_CKS: begin
            state_d = ck_match ? ST_BTYPE : ST_ERROR;
          end
          ST_ENTL: begin
            entry_lo_d = dn_data;
            state_d    = ST_ENTH;
          end
          ST_ENTH: begin
            entry_addr_d = {dn_data, entry_lo_q};
            state_d      = ST_DONE;
          end
          default: begin
          end
        endcase
      end
      // A byte arriving with the dn_go fall is processed first, then truncation applies.
      if (cas_is_busy(state_d) && !dn_go) begin
        state_d = ST_ERROR;
      end
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy  = cas_is_busy(state_q);
    done  = (state_q == ST_DONE);
    error = (state_q == ST_ERROR);
  end

  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign entry_addr = entry_addr_q;
  assign rom_hit    = rom_hit_q;

endmodule

// File: tb/tb_cas_loader.sv
// Self-checking bench for cas_loader: scoreboarded RAM writes plus per-scenario status checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_cas_loader;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        dn_go   = 1'b0;
  logic        dn_wr   = 1'b0;
  logic [7:0]  dn_data = 8'h00;
  logic [7:0]  dn_idx  = 8'h00;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] entry_addr;
  logic        rom_hit;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  logic [23:0] exp_q[$];

  cas_loader dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .dn_go      (dn_go),
    .dn_wr      (dn_wr),
    .dn_data    (dn_data),
    .dn_idx     (dn_idx),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .entry_addr (entry_addr),
    .rom_hit    (rom_hit)
  );

  always #5 clk_sys = ~clk_sys;

  // Scoreboard: every observed RAM write must match the oldest expected one.
  always @(negedge clk_sys) begin
    if (mem_wr === 1'b1) begin
      logic [23:0] exp;
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected got addr=%h data=%h, expected no write", mem_addr, mem_data);
      end else begin
        exp = exp_q.pop_front();
        if ({mem_addr, mem_data} !== exp)
          $display("FAIL wr_match got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_data, exp[23:8], exp[7:0]);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish, checks so far %0d", n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dn_data = b;
    dn_wr   = 1'b1;
    tick();
    dn_wr   = 1'b0;
    tick();
  endtask

  task automatic start_load();
    dn_go  = 1'b0;
    tick();
    dn_go  = 1'b1;
    dn_idx = 8'd1;
    tick();
  endtask

  task automatic send_header();
    logic [47:0] name;
    name = "PROG  ";
    repeat (3) send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'h55);
    for (int i = 5; i >= 0; i--) send_byte(name[i*8 +: 8]);
  endtask

  // Full data block; pushes the writes that should reach RAM and returns whether any is suppressed.
  task automatic send_block(input logic [15:0] addr, input int len, input logic [7:0] seed,
                            input logic [7:0] step, input logic [7:0] cks_delta,
                            output bit any_rom);
    logic [7:0]  cks;
    logic [7:0]  d;
    logic [15:0] a;
    any_rom = 1'b0;
    cks = addr[7:0] + addr[15:8];
    send_byte(8'h3C);
    send_byte(len[7:0]);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
    for (int i = 0; i < len; i++) begin
      d = seed + 8'(i) * step;
      a = addr + 16'(i);
      if (a >= 16'h4000) exp_q.push_back({a, d});
      else any_rom = 1'b1;
      cks = cks + d;
      send_byte(d);
    end
    send_byte(cks + cks_delta);
  endtask

  task automatic send_end(input logic [15:0] entry);
    send_byte(8'h78);
    send_byte(entry[7:0]);
    send_byte(entry[15:8]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({mem_wr, mem_addr, mem_data, busy, done, error, entry_addr, rom_hit} !== 44'h0)
      $display("FAIL reset_outputs got %h, expected 0",
               {mem_wr, mem_addr, mem_data, busy, done, error, entry_addr, rom_hit});
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b, expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit r;
    int w0;
    w0 = n_writes;
    start_load();
    n_checks++;
    if ({busy, done, error} !== 3'b100) $display("FAIL basic_start got %b, expected 100", {busy, done, error});
    else n_pass++;
    // A byte on another index must be ignored (0xFF in LEADER would be an error).
    dn_idx = 8'd2;
    send_byte(8'hFF);
    dn_idx = 8'd1;
    send_header();
    send_block(16'h5000, 2, 8'h11, 8'h11, 8'h00, r);
    n_checks++;
    if ({busy, done} !== 2'b10) $display("FAIL basic_mid got busy/done %b, expected 10", {busy, done});
    else n_pass++;
    send_end(16'h5000);
    n_checks++;
    if ({busy, done, error} !== 3'b010) $display("FAIL basic_flags got %b, expected 010", {busy, done, error});
    else n_pass++;
    n_checks++;
    if (entry_addr !== 16'h5000) $display("FAIL basic_entry got %h, expected 5000", entry_addr);
    else n_pass++;
    n_checks++;
    if ((n_writes - w0) !== 2 || exp_q.size() !== 0 || rom_hit !== r)
      $display("FAIL basic_writes got %0d writes rom_hit=%b, expected 2 writes rom_hit=%b", n_writes - w0, rom_hit, r);
    else n_pass++;
  endtask

  task automatic test_checksum();
    bit r;
    start_load();
    send_header();
    send_block(16'h5000, 2, 8'h11, 8'h11, 8'h01, r);
`ifdef CAS_CHECKSUM_EN
    n_checks++;
    if ({busy, done, error} !== 3'b001) $display("FAIL cks_bad got %b, expected 001", {busy, done, error});
    else n_pass++;
    send_end(16'h5000);
    n_checks++;
    if ({done, error} !== 2'b01) $display("FAIL cks_sticky got %b, expected 01", {done, error});
    else n_pass++;
`else
    n_checks++;
    if ({busy, done, error} !== 3'b100) $display("FAIL cks_ignored got %b, expected 100", {busy, done, error});
    else n_pass++;
    send_end(16'h5000);
    n_checks++;
    if ({done, error, entry_addr} !== {2'b10, 16'h5000})
      $display("FAIL cks_done got %b %h, expected 10 5000", {done, error}, entry_addr);
    else n_pass++;
`endif
  endtask

  task automatic test_len256();
    bit r;
    int w0;
    w0 = n_writes;
    start_load();
    send_header();
    send_block(16'h7000, 256, 8'h00, 8'h01, 8'h00, r);
    send_end(16'h7000);
    n_checks++;
    if ((n_writes - w0) !== 256 || exp_q.size() !== 0)
      $display("FAIL len256_writes got %0d, expected 256", n_writes - w0);
    else n_pass++;
    n_checks++;
    if ({done, error, entry_addr} !== {2'b10, 16'h7000})
      $display("FAIL len256_done got %b %h, expected 10 7000", {done, error}, entry_addr);
    else n_pass++;
  endtask

  task automatic test_rom();
    bit r;
    int w0;
    w0 = n_writes;
    start_load();
    send_header();
    send_block(16'h3FFE, 4, 8'hA0, 8'h01, 8'h00, r);
    send_end(16'h4000);
    n_checks++;
    if ((n_writes - w0) !== 2 || exp_q.size() !== 0)
      $display("FAIL rom_writes got %0d, expected 2", n_writes - w0);
    else n_pass++;
    n_checks++;
    if ({rom_hit, done, error} !== {r, 2'b10})
      $display("FAIL rom_flags got %b, expected %b10", {rom_hit, done, error}, r);
    else n_pass++;
  endtask

  task automatic test_truncation();
    bit r;
    start_load();
    n_checks++;
    if ({rom_hit, done, entry_addr} !== 18'h0)
      $display("FAIL trunc_start_clear got %b %b %h, expected 0 0 0000", rom_hit, done, entry_addr);
    else n_pass++;
    send_header();
    send_byte(8'h3C);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h50);
    exp_q.push_back({16'h5000, 8'h11});
    send_byte(8'h11);
    dn_go = 1'b0;
    n_checks++;
    if (error !== 1'b0) $display("FAIL trunc_early got error=%b, expected 0", error);
    else n_pass++;
    tick();
    n_checks++;
    if ({busy, error} !== 2'b01) $display("FAIL trunc_error got busy/error %b, expected 01", {busy, error});
    else n_pass++;
    start_load();
    n_checks++;
    if ({busy, error} !== 2'b10) $display("FAIL trunc_restart got busy/error %b, expected 10", {busy, error});
    else n_pass++;
    send_header();
    send_block(16'h5000, 2, 8'h11, 8'h11, 8'h00, r);
    send_end(16'h5000);
    n_checks++;
    if ({done, error, entry_addr} !== {2'b10, 16'h5000} || exp_q.size() !== 0)
      $display("FAIL trunc_reload got %b %h, expected 10 5000", {done, error}, entry_addr);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    start_load();
    send_header();
    send_byte(8'h3C);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h60);
    exp_q.push_back({16'h6000, 8'h77});
    dn_data = 8'h77;
    dn_wr   = 1'b1;
    dn_go   = 1'b0;
    tick();
    dn_wr   = 1'b0;
    n_checks++;
    if ({mem_wr, busy, error} !== 3'b101) $display("FAIL b2b_flags got %b, expected 101", {mem_wr, busy, error});
    else n_pass++;
    tick();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL b2b_write got %0d pending, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0;
    start_load();
    send_header();
    send_byte(8'h3C);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h50);
    exp_q.push_back({16'h5000, 8'hC1});
    send_byte(8'hC1);
    exp_q.push_back({16'h5001, 8'hC2});
    send_byte(8'hC2);
    reset = 1'b1;
    tick();
    n_checks++;
    if ({mem_wr, mem_addr, mem_data, busy, done, error, entry_addr, rom_hit} !== 44'h0)
      $display("FAIL reset_mid_outputs got %h, expected 0",
               {mem_wr, mem_addr, mem_data, busy, done, error, entry_addr, rom_hit});
    else n_pass++;
    reset = 1'b0;
    tick();
    w0 = n_writes;
    send_byte(8'h99);
    send_byte(8'h9A);
    n_checks++;
    if ((n_writes - w0) !== 0) $display("FAIL reset_mid_nowrite got %0d writes, expected 0", n_writes - w0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum();
    test_len256();
    test_rom();
    test_truncation();
    test_back_to_back();
    test_reset_mid();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
